// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
module riscv_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step, p_fix;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic              accept, sa, sb, ovf, b_zero;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  always_comb begin
    accept = in_valid & in_ready & ~flush;
    sa     = a[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sb     = b[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    a_mag  = sa ? -a : a;
    b_mag  = sb ? -b : b;
    b_zero = b == '0;
    ovf    = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    step   = acc_q;
    sum    = '0;
    // acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide
    for (int i = 0; i < STEP_BITS; i++) begin
      if (op_q[2]) begin
        sum  = {step[2*XLEN-1:XLEN], step[XLEN-1]} - {1'b0, b_q};
        step = sum[XLEN] ? {step[2*XLEN-2:0], 1'b0} : {sum[XLEN-1:0], step[XLEN-2:0], 1'b1};
      end else begin
        sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, b_q} : '0);
        step = {sum, step[XLEN-1:1]};
      end
    end
    p_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    q_fix = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d  = op;
        sa_d  = sa;
        sb_d  = sb;
        b_d   = b_mag;
        acc_d = {{XLEN{1'b0}}, a_mag};
        cnt_d = CW'(N - 1);
        if (op[2] & (b_zero | ovf)) begin
          state_d  = DONE;
          result_d = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = step;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : CALC;
      end
      FIX: begin
        result_d = op_q[2] ? (op_q[1] ? r_fix : q_fix)
                           : (op_q[1:0] == 2'b00 ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN]);
        state_d  = DONE;
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed vector table, multi-cycle corner sequences and a random regression
module tb_riscv_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  int          n_cmp = 0;
  int          n_fail = 0;

  riscv_muldiv_unit #(.XLEN(32), .STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        xs, ys, xu, yu, p;
    logic signed [31:0] sx, sy;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    xu = {32'd0, x};
    yu = {32'd0, y};
    sx = x;
    sy = y;
    case (f)
      3'd0: p = xu * yu;
      3'd1: p = xs * ys;
      3'd2: p = xs * yu;
      3'd3: p = xu * yu;
      default: p = '0;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (y == 0) ? 32'hFFFFFFFF : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: return (y == 0) ? x : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // accept one op, scramble operands afterwards, wait for out_valid, then hold off out_ready for 'hold' cycles
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int hold,
                        output logic [31:0] res, output int lat);
    op = f;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    repeat (hold) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res, held, x, y;
    logic [2:0]  f;
    int          lat;
    logic        ok;
    tv[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    tv[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    tv[2]  = '{3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 34};
    tv[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    tv[4]  = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 34};
    tv[5]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 34};
    tv[6]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    tv[7]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    tv[8]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
    tv[9]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
    tv[10] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    tv[11] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
    tv[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tv[13] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tv[14] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    tv[15] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    tv[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tv[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tv[18] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, 0, res, lat);
      check($sformatf("vec%0d result", i), res, tv[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(tv[i].lat));
    end

    // backpressure: result held 10 cycles, then the next op is accepted right after the handshake
    op = 3'd3;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = result;
    ok = out_valid;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      ok = ok & out_valid & ~in_ready & (result == held);
    end
    check("bp stable", 32'(ok), 32'd1);
    check("bp result", held, 32'hFFFFFFFE);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    run_op(3'd5, 32'd100, 32'd7, 0, res, lat);
    check("bp next op", res, 32'd14);

    // flush mid-CALC
    op = 3'd0;
    a = 32'd3;
    b = 32'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      ok = ok | out_valid;
    end
    check("flush no out_valid", 32'(ok), 32'd0);

    // flush together with in_valid in IDLE
    op = 3'd4;
    a = 32'd5;
    b = 32'd0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush beats accept", 32'(in_ready), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      ok = ok | out_valid;
    end
    check("flush accept no out_valid", 32'(ok), 32'd0);

    // flush beats the handshake in DONE
    op = 3'd5;
    a = 32'd5;
    b = 32'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("special done", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush in done", 32'(out_valid), 32'd0);

    // asynchronous reset mid-CALC
    run_op(3'd5, 32'd100, 32'd7, 0, res, lat);
    op = 3'd0;
    a = 32'd9;
    b = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // random regression with corner-weighted operands and random backpressure
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 5))
        0: x = 32'h80000000;
        1: x = 32'hFFFFFFFF;
        2: x = 32'd0;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'hFFFFFFFF;
        1: y = 32'd0;
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_op(f, x, y, $urandom_range(0, 3), res, lat);
      check($sformatf("rand%0d op%0d a=%08h b=%08h", i, f, x, y), res, ref_model(f, x, y));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
